axi2uart_fifo: RTL and testbench
================================

Name: axi2uart_fifo

Overview:
- AXI4 slave bridge between the PS and the Camera Link serial (UART) port.
- Generalises the single-byte AXI-to-UART bridge with parametrised TX/RX byte FIFOs, burst-capable data paths, write backpressure, RX overflow detection, a status register and a parametrised CC width.
- Sits between the AXI interconnect and the UART TX/RX engines plus the camera CC lines.

Parameters:
- AXI_ADDR_WIDTH, 6, AXI address width.
- AXI_DATA_WIDTH, 128, AXI data width (>=32).
- TX_DEPTH, 16, TX FIFO depth in bytes (power of 2, >=2).
- RX_DEPTH, 16, RX FIFO depth in bytes (power of 2, >=2).
- CC_WIDTH, 4, number of camera control lines (1..8).

Ports:
- s_axi_aclk  in  1  clock.
- s_axi_areset  in  1  asynchronous, active-high reset.
- s_axi_aw{addr,id,len,size,burst,valid}/awready  AW channel; widths AXI_ADDR_WIDTH/16/8/3/2/1.
- s_axi_w{data,strb,valid,last}/wready  W channel; wstrb is ignored.
- s_axi_b{resp,id,valid}/bready  B channel.
- s_axi_ar{addr,id,len,size,burst,valid}/arready  AR channel.
- s_axi_r{data,resp,id,valid,last}/rready  R channel.
- tx_start  out  1  one-cycle pulse; launches tx_data.
- tx_data  out  8  byte to transmit.
- tx_busy  in  1  UART transmitter busy.
- rx_ready  in  1  one-cycle strobe; rx_data is valid.
- rx_data  in  8  received byte.
- cc  out  CC_WIDTH  camera control lines.

Behaviour:
- Reset (async, active-high): every output 0, FIFOs empty, rx_overflow=0, all FSMs idle. Applying reset mid-burst abandons the transaction with no response.
- Address map, decoded on addr[5:4] with addr[3:0] ignored:
  - 0x00 W: TX data; each beat pushes wdata[7:0].
  - 0x10 W: cc <= wdata[CC_WIDTH-1:0] on every beat.
  - 0x20 R: RX pop; rdata[8]=valid, rdata[7:0]=byte. If empty: rdata=0, no pop.
  - 0x30 R: status. [0]=rx_empty, [1]=tx_full, [2]=rx_overflow, [15:8]=tx_count, [23:16]=rx_count.
  - 0x30 W: wdata[2]=1 clears rx_overflow.
  - 0x20 W and 0x00/0x10 R are unmapped: SLVERR.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - awready=1 only in W_IDLE; on the AW handshake, latch awid and the target.
  - In W_DATA, wready=1 except for TX target with TX FIFO full (backpressure). Unmapped targets still accept and discard beats.
  - A beat with wlast=1 moves to W_RESP.
  - W_RESP: bvalid=1, bid=awid, bresp=OKAY or SLVERR (2'b10). bvalid holds until bready; then return to W_IDLE.
  - Beat count is ended by wlast, not awlen.
- Read FSM R_IDLE -> R_DATA:
  - arready=1 only in R_IDLE; on the AR handshake, latch arid, target and beats=arlen+1.
  - R_DATA drives rvalid=1 with rid=arid and rlast on the final beat; rdata/rresp stay stable until rready.
  - RX pop occurs exactly at each rvalid&rready handshake. The next beat's data is presented the cycle after the handshake.
  - After the last handshake, return to R_IDLE.
- TX drain FSM:
  - T_IDLE: if TX FIFO is not empty and tx_busy=0, pop; tx_data<=head; tx_start=1 for one cycle; go to T_WAIT.
  - T_WAIT: wait for tx_busy=1, then T_DONE; wait for tx_busy=0, then T_IDLE.
  - If tx_busy is not seen within 4 cycles of entering T_WAIT, go to T_IDLE.
  - tx_data holds its value between pulses.
- RX:
  - rx_ready=1 with RX not full pushes rx_data.
  - rx_ready=1 with RX full drops the byte and sets rx_overflow (sticky). The flag clears only via a 0x30 write; set wins over a simultaneous clear.
- FIFOs: count width clog2(DEPTH)+1. A simultaneous push and pop in the same cycle leaves count unchanged and is legal even when full (RX) or empty-pre-push is not allowed (pop needs a non-empty FIFO). Pointers wrap modulo DEPTH.
- The write and read FSMs run independently and concurrently.

Test Plan:
- Reset, then read 0x30 with arlen=0 -> rdata=0x00000001 (rx_empty), rresp=OKAY, rlast=1.
- Write burst to 0x00, awlen=3, bytes 0x41..0x44; tx_busy model high for 10 cycles after each tx_start -> four tx_start pulses with tx_data 0x41, 0x42, 0x43, 0x44 in order; bresp=OKAY, bid=awid.
- TX_DEPTH=16 and tx_busy held high, write a 20-beat burst -> wready low after 16 beats; status tx_full=1; releasing tx_busy completes the burst and all 20 bytes go out in order.
- 17 rx_ready strobes (0x00..0x10) with RX_DEPTH=16 -> status rx_count=16, rx_overflow=1. Read 0x20 arlen=16 -> beats 0x100..0x10F, then a final beat rdata=0. Write 0x30 wdata=4 -> rx_overflow=0.
- Write 0x10 wdata=0xA -> cc=4'b1010. Write 0x20 -> bresp=SLVERR. Read 0x00 -> rresp=SLVERR, rlast=1.
- Assert s_axi_areset mid-way through a TX burst -> all outputs 0 asynchronously; after release awready=1 and status reads 0x00000001.

Source files
------------

// File: rtl/axi2uart_fifo.sv
// AXI4 slave bridge: W bursts feed a UART TX byte FIFO / CC register, R bursts pop an RX byte FIFO or read status.
// Latency: AR handshake -> first R beat 2 cycles, 1 idle cycle between R beats; TX byte -> tx_start 1 cycle after it reaches the head.
// Backpressure: wready drops while the TX FIFO is full; R beats hold until rready; a full RX FIFO drops bytes and flags overflow.
module axi2uart_fifo #(
  parameter int AXI_ADDR_WIDTH = 6,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int TX_DEPTH       = 16,
  parameter int RX_DEPTH       = 16,
  parameter int CC_WIDTH       = 4
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_areset,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [15:0]                 s_axi_awid,
  input  logic [7:0]                  s_axi_awlen,
  input  logic [2:0]                  s_axi_awsize,
  input  logic [1:0]                  s_axi_awburst,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                        s_axi_wvalid,
  input  logic                        s_axi_wlast,
  output logic                        s_axi_wready,
  output logic [1:0]                  s_axi_bresp,
  output logic [15:0]                 s_axi_bid,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [15:0]                 s_axi_arid,
  input  logic [7:0]                  s_axi_arlen,
  input  logic [2:0]                  s_axi_arsize,
  input  logic [1:0]                  s_axi_arburst,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic [15:0]                 s_axi_rid,
  output logic                        s_axi_rvalid,
  output logic                        s_axi_rlast,
  input  logic                        s_axi_rready,
  output logic                        tx_start,
  output logic [7:0]                  tx_data,
  input  logic                        tx_busy,
  input  logic                        rx_ready,
  input  logic [7:0]                  rx_data,
  output logic [CC_WIDTH-1:0]         cc
);
  localparam logic [1:0] SEL_TX = 2'd0, SEL_CC = 2'd1, SEL_RX = 2'd2, SEL_ST = 2'd3;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW-1:0] TX_PTR_ONE = TX_AW'(1);
  localparam logic [RX_AW-1:0] RX_PTR_ONE = RX_AW'(1);
  localparam logic [TX_AW:0]   TX_CNT_ONE = (TX_AW+1)'(1);
  localparam logic [RX_AW:0]   RX_CNT_ONE = (RX_AW+1)'(1);
  localparam logic [TX_AW:0]   TX_CNT_FULL = (TX_AW+1)'(TX_DEPTH);
  localparam logic [RX_AW:0]   RX_CNT_FULL = (RX_AW+1)'(RX_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_DATA} rstate_t;
  typedef enum logic [1:0] {T_IDLE, T_WAIT, T_DONE} tstate_t;

  wstate_t wstate;
  rstate_t rstate;
  tstate_t tstate;

  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wp, tx_rp;
  logic [TX_AW:0]   tx_count;
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wp, rx_rp;
  logic [RX_AW:0]   rx_count;
  logic tx_push, tx_pop, tx_empty, tx_full;
  logic rx_push, rx_pop, rx_empty, rx_full;
  logic rx_overflow, ovf_set, ovf_clr;
  logic [1:0] w_sel, r_sel, t_cnt;
  logic [7:0] r_left;
  logic w_beat;
  logic [AXI_DATA_WIDTH-1:0] load_data;
  logic [1:0] load_resp;
  logic unused_bits;

  assign unused_bits = ^{s_axi_awaddr[3:0], s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_wstrb,
                         s_axi_wdata[AXI_DATA_WIDTH-1:8], s_axi_araddr[3:0], s_axi_arsize, s_axi_arburst};

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == TX_CNT_FULL);
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == RX_CNT_FULL);

  // Only the TX target can stall the W channel; other targets swallow beats
  assign s_axi_wready = (wstate == W_DATA) && !((w_sel == SEL_TX) && tx_full);
  assign w_beat  = s_axi_wvalid && s_axi_wready;
  assign tx_push = w_beat && (w_sel == SEL_TX);
  assign ovf_clr = w_beat && (w_sel == SEL_ST) && s_axi_wdata[2];
  assign tx_pop  = (tstate == T_IDLE) && !tx_empty && !tx_busy;

  // A pop beat only carries a byte when it was latched with the valid flag set
  assign rx_pop  = s_axi_rvalid && s_axi_rready && (r_sel == SEL_RX) && s_axi_rdata[8];
  // A byte arriving into a full FIFO is still taken if a pop frees a slot that cycle
  assign rx_push = rx_ready && (!rx_full || rx_pop);
  assign ovf_set = rx_ready && rx_full && !rx_pop;

  // TX FIFO pointers and occupancy
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      tx_wp <= '0; tx_rp <= '0; tx_count <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + TX_PTR_ONE;
      if (tx_pop)  tx_rp <= tx_rp + TX_PTR_ONE;
      if (tx_push && !tx_pop)      tx_count <= tx_count + TX_CNT_ONE;
      else if (tx_pop && !tx_push) tx_count <= tx_count - TX_CNT_ONE;
    end
  end

  // TX storage needs no reset: the pointers define which entries are live
  always_ff @(posedge s_axi_aclk) begin
    if (tx_push) tx_mem[tx_wp] <= s_axi_wdata[7:0];
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      rx_wp <= '0; rx_rp <= '0; rx_count <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + RX_PTR_ONE;
      if (rx_pop)  rx_rp <= rx_rp + RX_PTR_ONE;
      if (rx_push && !rx_pop)      rx_count <= rx_count + RX_CNT_ONE;
      else if (rx_pop && !rx_push) rx_count <= rx_count - RX_CNT_ONE;
    end
  end

  // RX storage, unreset for the same reason as TX
  always_ff @(posedge s_axi_aclk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_data;
  end

  // Sticky overflow flag; a new drop outranks a software clear in the same cycle
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset)  rx_overflow <= 1'b0;
    else if (ovf_set)  rx_overflow <= 1'b1;
    else if (ovf_clr)  rx_overflow <= 1'b0;
  end

  // Write FSM: accept AW, consume beats until wlast, then hold the B response
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      wstate <= W_IDLE; s_axi_awready <= 1'b0; w_sel <= SEL_TX;
      s_axi_bid <= '0; s_axi_bresp <= RESP_OKAY; s_axi_bvalid <= 1'b0; cc <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awvalid && s_axi_awready) begin
            s_axi_awready <= 1'b0;
            w_sel         <= s_axi_awaddr[5:4];
            s_axi_bid     <= s_axi_awid;
            s_axi_bresp   <= (s_axi_awaddr[5:4] == SEL_RX) ? RESP_SLVERR : RESP_OKAY;
            wstate        <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            if (w_sel == SEL_CC) cc <= s_axi_wdata[CC_WIDTH-1:0];
            if (s_axi_wlast) begin
              s_axi_bvalid <= 1'b1;
              wstate       <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            wstate       <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Beat contents sampled from the current FIFO/status state one cycle after AR or the previous handshake
  always_comb begin
    load_data = '0;
    load_resp = RESP_OKAY;
    case (r_sel)
      SEL_RX: if (!rx_empty) load_data[8:0] = {1'b1, rx_mem[rx_rp]};
      SEL_ST: begin
        load_data[0]     = rx_empty;
        load_data[1]     = tx_full;
        load_data[2]     = rx_overflow;
        load_data[15:8]  = 8'(tx_count);
        load_data[23:16] = 8'(rx_count);
      end
      default: load_resp = RESP_SLVERR;
    endcase
  end

  // Read FSM: the R_LOAD bubble lets a pop settle before the next beat is latched
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      rstate <= R_IDLE; s_axi_arready <= 1'b0; r_sel <= SEL_TX; r_left <= '0;
      s_axi_rid <= '0; s_axi_rdata <= '0; s_axi_rresp <= RESP_OKAY;
      s_axi_rvalid <= 1'b0; s_axi_rlast <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (s_axi_arvalid && s_axi_arready) begin
            s_axi_arready <= 1'b0;
            r_sel         <= s_axi_araddr[5:4];
            s_axi_rid     <= s_axi_arid;
            r_left        <= s_axi_arlen;
            rstate        <= R_LOAD;
          end
        end
        R_LOAD: begin
          s_axi_rvalid <= 1'b1;
          s_axi_rdata  <= load_data;
          s_axi_rresp  <= load_resp;
          s_axi_rlast  <= (r_left == 8'd0);
          rstate       <= R_DATA;
        end
        R_DATA: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rlast  <= 1'b0;
            if (r_left == 8'd0) rstate <= R_IDLE;
            else begin
              r_left <= r_left - 8'd1;
              rstate <= R_LOAD;
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // TX drain FSM: launch a byte, then follow the UART busy handshake (with a short timeout)
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      tstate <= T_IDLE; tx_start <= 1'b0; tx_data <= '0; t_cnt <= '0;
    end else begin
      tx_start <= 1'b0;
      case (tstate)
        T_IDLE: begin
          if (tx_pop) begin
            tx_data  <= tx_mem[tx_rp];
            tx_start <= 1'b1;
            t_cnt    <= '0;
            tstate   <= T_WAIT;
          end
        end
        T_WAIT: begin
          if (tx_busy)             tstate <= T_DONE;
          else if (t_cnt == 2'd3)  tstate <= T_IDLE;
          else                     t_cnt  <= t_cnt + 2'd1;
        end
        T_DONE: if (!tx_busy) tstate <= T_IDLE;
        default: tstate <= T_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi2uart_fifo.sv
// Self-checking bench for axi2uart_fifo: directed steps plus randomized bursts against a queue model.
// Latency: checks are cycle-agnostic except where the behaviour is defined (reset, backpressure).
// Backpressure: a UART busy model and optional random rready stalls exercise both directions.
module tb_axi2uart_fifo;
  localparam int DW = 128;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [5:0]   s_axi_awaddr = '0;
  logic [15:0]  s_axi_awid = '0;
  logic [7:0]   s_axi_awlen = '0;
  logic [2:0]   s_axi_awsize = '0;
  logic [1:0]   s_axi_awburst = '0;
  logic         s_axi_awvalid = 1'b0;
  logic         s_axi_awready;
  logic [DW-1:0] s_axi_wdata = '0;
  logic [DW/8-1:0] s_axi_wstrb = '1;
  logic         s_axi_wvalid = 1'b0;
  logic         s_axi_wlast = 1'b0;
  logic         s_axi_wready;
  logic [1:0]   s_axi_bresp;
  logic [15:0]  s_axi_bid;
  logic         s_axi_bvalid;
  logic         s_axi_bready = 1'b0;
  logic [5:0]   s_axi_araddr = '0;
  logic [15:0]  s_axi_arid = '0;
  logic [7:0]   s_axi_arlen = '0;
  logic [2:0]   s_axi_arsize = '0;
  logic [1:0]   s_axi_arburst = '0;
  logic         s_axi_arvalid = 1'b0;
  logic         s_axi_arready;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic [15:0]  s_axi_rid;
  logic         s_axi_rvalid;
  logic         s_axi_rlast;
  logic         s_axi_rready = 1'b0;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic         tx_busy = 1'b0;
  logic         rx_ready = 1'b0;
  logic [7:0]   rx_data = '0;
  logic [3:0]   cc;

  axi2uart_fifo #(.AXI_ADDR_WIDTH(6), .AXI_DATA_WIDTH(DW), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH), .CC_WIDTH(4)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wlast(s_axi_wlast), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bid(s_axi_bid), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rid(s_axi_rid),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rlast(s_axi_rlast), .s_axi_rready(s_axi_rready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .rx_ready(rx_ready), .rx_data(rx_data), .cc(cc)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  bit ovf_m = 1'b0;
  int tx_seen = 0;
  bit hold_busy = 1'b0;
  int beats_done = 0;

  logic [DW-1:0] wbeat[$];
  logic [DW-1:0] r_dat[$];
  logic [1:0]    r_resp[$];
  logic          r_last[$];
  logic [15:0]   r_id[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] status_exp(input int txc);
    logic [127:0] v;
    v = '0;
    v[0] = (rx_q.size() == 0);
    v[1] = (txc == DEPTH);
    v[2] = ovf_m;
    v[15:8] = 8'(txc);
    v[23:16] = 8'(rx_q.size());
    return v;
  endfunction

  // UART model: busy for 10 cycles after each launch, or forced high; every launch checked against the model
  initial begin : uart_model
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0;
        tx_busy = hold_busy;
      end else begin
        if (tx_start) begin
          tx_seen++;
          if (tx_q.size() == 0) chk("tx_spurious", {127'b0, tx_start}, 128'd0);
          else chk("tx_byte", {120'b0, tx_data}, {120'b0, tx_q.pop_front()});
          cnt = 10;
        end
        if (hold_busy) tx_busy = 1'b1;
        else if (cnt > 0) begin tx_busy = 1'b1; cnt--; end
        else tx_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  task automatic axi_write(input logic [5:0] addr, input logic [15:0] id,
                           output logic [1:0] resp, output logic [15:0] bid_o);
    int n, t;
    n = wbeat.size();
    @(negedge clk);
    s_axi_awaddr = addr; s_axi_awid = id; s_axi_awlen = 8'(n - 1);
    s_axi_awsize = 3'd4; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
    t = 0;
    while (!s_axi_awready && t < 200) begin @(negedge clk); t++; end
    if (!s_axi_awready) chk("aw_handshake", {127'b0, s_axi_awready}, 128'd1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_axi_wdata = wbeat[i]; s_axi_wvalid = 1'b1; s_axi_wlast = (i == n - 1);
      t = 0;
      while (!s_axi_wready && t < 3000) begin @(negedge clk); t++; end
      if (!s_axi_wready) chk("w_handshake", {127'b0, s_axi_wready}, 128'd1);
      @(negedge clk);
      beats_done++;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
    t = 0;
    while (!s_axi_bvalid && t < 200) begin @(negedge clk); t++; end
    if (!s_axi_bvalid) chk("b_handshake", {127'b0, s_axi_bvalid}, 128'd1);
    resp = s_axi_bresp; bid_o = s_axi_bid;
    @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] addr, input logic [15:0] id, input int n, input bit stall);
    int t;
    r_dat.delete(); r_resp.delete(); r_last.delete(); r_id.delete();
    @(negedge clk);
    s_axi_araddr = addr; s_axi_arid = id; s_axi_arlen = 8'(n - 1);
    s_axi_arsize = 3'd4; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    t = 0;
    while (!s_axi_arready && t < 200) begin @(negedge clk); t++; end
    if (!s_axi_arready) chk("ar_handshake", {127'b0, s_axi_arready}, 128'd1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    t = 0;
    while (r_dat.size() < n && t < 1000) begin
      s_axi_rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s_axi_rvalid && s_axi_rready) begin
        r_dat.push_back(s_axi_rdata); r_resp.push_back(s_axi_rresp);
        r_last.push_back(s_axi_rlast); r_id.push_back(s_axi_rid);
      end
      @(negedge clk);
      t++;
    end
    s_axi_rready = 1'b0;
    chk("r_beat_count", 128'(r_dat.size()), 128'(n));
    repeat (2) @(negedge clk);
    chk("r_no_extra_beat", {127'b0, s_axi_rvalid}, 128'd0);
  endtask

  task automatic read_status(input string tag, input int txc);
    logic [15:0] id;
    id = 16'($urandom);
    axi_read(6'h30, id, 1, 1'b0);
    if (r_dat.size() == 1) begin
      chk({tag, "_data"}, r_dat[0], status_exp(txc));
      chk({tag, "_resp_last_id"}, {109'b0, r_resp[0], r_last[0], r_id[0]}, {109'b0, 2'b00, 1'b1, id});
    end
  endtask

  task automatic rx_strobe(input logic [7:0] v);
    @(negedge clk);
    rx_ready = 1'b1; rx_data = v;
    if (rx_q.size() < DEPTH) rx_q.push_back(v); else ovf_m = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic rx_read(input int n, input bit stall);
    logic [15:0] id;
    logic [127:0] exp;
    id = 16'($urandom);
    axi_read(6'h20, id, n, stall);
    for (int i = 0; i < r_dat.size(); i++) begin
      exp = '0;
      if (rx_q.size() > 0) exp[8:0] = {1'b1, rx_q.pop_front()};
      chk("rx_pop_data", r_dat[i], exp);
      chk("rx_pop_resp_last_id", {109'b0, r_resp[i], r_last[i], r_id[i]},
          {109'b0, 2'b00, (i == n - 1), id});
    end
  endtask

  task automatic tx_burst(input logic [15:0] id, input int n, input bit fixed);
    logic [127:0] v;
    logic [1:0] resp;
    logic [15:0] bidv;
    wbeat.delete();
    for (int i = 0; i < n; i++) begin
      v = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (fixed) v[7:0] = 8'h41 + 8'(i);
      wbeat.push_back(v);
      tx_q.push_back(v[7:0]);
    end
    axi_write(6'h00, id, resp, bidv);
    chk("tx_bresp_bid", {110'b0, resp, bidv}, {110'b0, 2'b00, id});
  endtask

  task automatic wait_tx_drain();
    int t;
    t = 0;
    while ((tx_q.size() > 0 || tx_busy) && t < 5000) begin @(negedge clk); t++; end
    chk("tx_drained", 128'(tx_q.size()), 128'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic reg_write(input logic [5:0] addr, input logic [127:0] val, input logic [1:0] exp_resp);
    logic [1:0] resp;
    logic [15:0] bidv, id;
    id = 16'($urandom);
    wbeat.delete();
    wbeat.push_back(val);
    axi_write(addr, id, resp, bidv);
    chk("reg_bresp_bid", {110'b0, resp, bidv}, {110'b0, exp_resp, id});
  endtask

  initial begin : main
    int seen0, n, k;
    logic [3:0] ccv;
    logic [127:0] v;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {73'b0, s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_bid,
         s_axi_arready, s_axi_rvalid, s_axi_rlast, s_axi_rresp, s_axi_rid, tx_start, tx_data, cc}, 128'd0);
    chk("reset_rdata", s_axi_rdata, 128'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Status after reset
    axi_read(6'h30, 16'h0005, 1, 1'b0);
    if (r_dat.size() == 1) begin
      chk("status_after_reset", r_dat[0], 128'h1);
      chk("status_resp_last_id", {109'b0, r_resp[0], r_last[0], r_id[0]}, {109'b0, 2'b00, 1'b1, 16'h0005});
    end

    // Fixed four-byte TX burst
    seen0 = tx_seen;
    tx_burst(16'h1234, 4, 1'b1);
    wait_tx_drain();
    chk("tx_four_pulses", 128'(tx_seen - seen0), 128'd4);

    // Backpressure: UART stuck busy, 20-beat burst stalls after 16
    hold_busy = 1'b1;
    repeat (3) @(negedge clk);
    beats_done = 0;
    seen0 = tx_seen;
    fork
      tx_burst(16'h0BEE, 20, 1'b0);
      begin
        for (int t = 0; t < 500 && beats_done < DEPTH; t++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("bp_beats_accepted", 128'(beats_done), 128'(DEPTH));
        chk("bp_wready_low", {127'b0, s_axi_wready}, 128'd0);
        read_status("bp_status", DEPTH);
        hold_busy = 1'b0;
      end
    join
    wait_tx_drain();
    chk("bp_all_sent", 128'(tx_seen - seen0), 128'd20);

    // RX overflow: 17 strobes into a 16-entry FIFO
    for (int i = 0; i <= 16; i++) rx_strobe(8'(i));
    read_status("rx_full_status", 0);
    rx_read(17, 1'b0);
    reg_write(6'h30, 128'h0, 2'b00);
    read_status("ovf_kept_status", 0);
    reg_write(6'h30, 128'h4, 2'b00);
    ovf_m = 1'b0;
    read_status("ovf_cleared_status", 0);

    // CC lines and unmapped targets
    reg_write(6'h10, 128'hA, 2'b00);
    chk("cc_0xA", {124'b0, cc}, 128'hA);
    wbeat.delete();
    for (int i = 0; i < 3; i++) begin
      v = {$urandom(), $urandom(), $urandom(), $urandom()};
      wbeat.push_back(v);
    end
    ccv = wbeat[2][3:0];
    begin
      logic [1:0] resp;
      logic [15:0] bidv;
      axi_write(6'h1C, 16'h0C0C, resp, bidv);
      chk("cc_burst_last_beat", {122'b0, resp, cc}, {122'b0, 2'b00, ccv});
    end
    reg_write(6'h20, 128'h55, 2'b10);
    axi_read(6'h00, 16'h0077, 1, 1'b0);
    if (r_dat.size() == 1)
      chk("rd_unmapped_00", {109'b0, r_resp[0], r_last[0], r_id[0]}, {109'b0, 2'b10, 1'b1, 16'h0077});
    axi_read(6'h10, 16'h0078, 3, 1'b1);
    for (int i = 0; i < r_dat.size(); i++)
      chk("rd_unmapped_10", {109'b0, r_resp[i], r_last[i], r_id[i]}, {109'b0, 2'b10, (i == 2), 16'h0078});

    // Randomized rounds
    for (int round = 0; round < 4; round++) begin
      n = $urandom_range(1, 8);
      seen0 = tx_seen;
      tx_burst(16'($urandom), n, 1'b0);
      wait_tx_drain();
      chk("rand_tx_pulses", 128'(tx_seen - seen0), 128'(n));
      k = $urandom_range(0, 20);
      for (int i = 0; i < k; i++) rx_strobe(8'($urandom));
      read_status("rand_status", 0);
      rx_read($urandom_range(1, 20), 1'b1);
      if (ovf_m) begin
        reg_write(6'h30, 128'h4, 2'b00);
        ovf_m = 1'b0;
      end
      read_status("rand_status_after", 0);
    end

    // Asynchronous reset in the middle of a TX burst
    reg_write(6'h10, 128'h5, 2'b00);
    hold_busy = 1'b1;
    @(negedge clk);
    s_axi_awaddr = 6'h00; s_axi_awid = 16'hDEAD; s_axi_awlen = 8'd7; s_axi_awvalid = 1'b1;
    for (int t = 0; t < 100 && !s_axi_awready; t++) @(negedge clk);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    s_axi_wdata = 128'h99; s_axi_wvalid = 1'b1; s_axi_wlast = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs", {73'b0, s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_bid,
         s_axi_arready, s_axi_rvalid, s_axi_rlast, s_axi_rresp, s_axi_rid, tx_start, tx_data, cc}, 128'd0);
    s_axi_wvalid = 1'b0;
    rx_q.delete();
    ovf_m = 1'b0;
    @(negedge clk);
    hold_busy = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("awready_after_reset", {127'b0, s_axi_awready}, 128'd1);
    read_status("status_after_async_reset", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
